// File: rtl/w_mem_read_sequencer.sv
// Pairs each accepted input word with its weight-ROM read and presents the aligned pair to the neuron MAC.
// Optional feature WSEQ_TIMEOUT_EN: abort a pass with an err pulse after timeoutCycles idle RUN cycles.
module w_mem_read_sequencer #(
  parameter int numWeight     = 30,
  parameter int addressWidth  = $clog2(numWeight),
  parameter int dataWidth     = 16,
  parameter int timeoutCycles = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [dataWidth-1:0]    in_data,
  output logic                    mem_ren,
  output logic [addressWidth-1:0] mem_radd,
  input  logic [dataWidth-1:0]    mem_rdata,
  output logic                    mac_valid,
  output logic [dataWidth-1:0]    mac_x,
  output logic [dataWidth-1:0]    mac_w,
  output logic                    mac_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [addressWidth-1:0] lastAddr = addressWidth'(numWeight - 1);

  if (numWeight < 2) begin : g_bad_num_weight
    $error("w_mem_read_sequencer: numWeight must be at least 2");
  end
  if (timeoutCycles < 1) begin : g_bad_timeout
    $error("w_mem_read_sequencer: timeoutCycles must be at least 1");
  end

  state_t                  state;
  state_t                  state_next;
  logic [addressWidth-1:0] cnt;
  logic [addressWidth-1:0] cnt_next;
  logic [dataWidth-1:0]    x_q;
  logic                    v_q;
  logic                    last_q;
  logic                    accept;
  logic                    at_last;
  logic                    abort;

  assign accept  = in_valid & (state == RUN);
  assign at_last = (cnt == lastAddr);

`ifdef WSEQ_TIMEOUT_EN
  localparam int idleWidth = $clog2(timeoutCycles + 1);

  logic [idleWidth-1:0] idle_cnt;

  // err fires in the idle cycle whose increment would bring the counter to timeoutCycles
  assign abort = (state == RUN) & ~accept & (idle_cnt == idleWidth'(timeoutCycles - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if ((state != RUN) || accept) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (at_last) begin
            state_next = DRAIN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end else if (abort) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The ROM read is issued in the accept cycle, so registering x here lines it up with wout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      x_q    <= '0;
      v_q    <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      v_q   <= accept;
      if (accept) begin
        x_q    <= in_data;
        last_q <= at_last;
      end
    end
  end

  assign in_ready  = (state == RUN);
  assign mem_ren   = accept;
  assign mem_radd  = cnt;
  assign busy      = (state == RUN) | (state == DRAIN);
  assign done      = (state == DONE);
  assign err       = abort;
  assign mac_valid = v_q;
  assign mac_x     = x_q;
  assign mac_w     = mem_rdata;
  assign mac_last  = v_q & last_q;

endmodule

// File: tb/tb_w_mem_read_sequencer.sv
// Directed self-checking bench for w_mem_read_sequencer with a registered-read weight ROM model.
// Covers reset, full and bubbly passes, ignored starts, idle inputs and the WSEQ_TIMEOUT_EN build.
module tb_w_mem_read_sequencer;
  localparam int NW = 30;
  localparam int AW = $clog2(NW);
  localparam int DW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          mem_ren;
  logic [AW-1:0] mem_radd;
  logic [DW-1:0] mem_rdata;
  logic          mac_valid;
  logic [DW-1:0] mac_x;
  logic [DW-1:0] mac_w;
  logic          mac_last;
  logic          busy;
  logic          done;
  logic          err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DW-1:0] rom [NW];

  typedef struct {
    int            c;
    logic [DW-1:0] x;
    logic [DW-1:0] w;
    logic          last;
  } pair_t;

  pair_t         pairs[$];
  int            acc[$];
  logic [AW-1:0] addrs[$];
  int            done_cyc[$];
  int            err_cyc[$];
  int            ren_bad;
  int            stray_last;
  logic          prev_busy = 1'b0;
  logic          busy_at_done;
  logic          busy_before_done;

  w_mem_read_sequencer #(
    .numWeight(NW), .dataWidth(DW), .timeoutCycles(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mem_ren(mem_ren), .mem_radd(mem_radd), .mem_rdata(mem_rdata),
    .mac_valid(mac_valid), .mac_x(mac_x), .mac_w(mac_w), .mac_last(mac_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // W_Mem-style weight ROM: one-cycle registered read
  always @(posedge clk) if (mem_ren) mem_rdata <= rom[mem_radd];

  always @(negedge clk) begin
    if (!rst) begin
      if (mac_valid) pairs.push_back('{cyc, mac_x, mac_w, mac_last});
      if (mac_last && !mac_valid) stray_last++;
      if (mem_ren) begin
        addrs.push_back(mem_radd);
        acc.push_back(cyc);
      end
      if (mem_ren !== (in_valid & in_ready)) ren_bad++;
      if (done) begin
        done_cyc.push_back(cyc);
        busy_at_done     = busy;
        busy_before_done = prev_busy;
      end
      if (err) err_cyc.push_back(cyc);
    end
    prev_busy = busy;
  end

  function automatic logic [DW-1:0] rom_val(input int k);
    return DW'(16'h5000 + k * 37);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pairs.delete(); acc.delete(); addrs.delete(); done_cyc.delete(); err_cyc.delete();
    ren_bad = 0; stray_last = 0;
  endtask

  task automatic start_pass();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  // Drives NW input words; bubbly alternates valid/idle, pulse_at raises start on that accept
  task automatic run_inputs(input bit bubbly, input int pulse_at, output int got);
    int k = 0;
    int g = 0;
    while (k < NW && g < 4 * NW) begin
      in_valid = bubbly ? ~g[0] : 1'b1;
      in_data  = in_valid ? DW'(100 + k) : 16'hDEAD;
      start    = (k == pulse_at) && in_valid;
      @(negedge clk);
      if (in_valid && in_ready) k++;
      next_cycle();
      g++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    got      = k;
  endtask

  task automatic test_reset();
    int got;
    int bad;
    #2;
    checks++;
    if ({mac_valid, mac_last, done, err, busy, in_ready, mem_ren} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b want=0000000",
               {mac_valid, mac_last, done, err, busy, in_ready, mem_ren});
    end
    checks++;
    if (mac_x !== '0 || mem_radd !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data mac_x=%h mem_radd=%0d want 0/0", mac_x, mem_radd);
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();
    start_pass();
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(500 + k);
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (mem_radd !== AW'(12)) begin
      failures++;
      $display("[TB] FAIL midpass_addr got=%0d want=12", mem_radd);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({mac_valid, mac_last, done, err, busy, in_ready, mem_ren} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL midpass_reset_ctrl got=%b want=0000000",
               {mac_valid, mac_last, done, err, busy, in_ready, mem_ren});
    end
    checks++;
    if (mac_x !== '0 || mem_radd !== '0) begin
      failures++;
      $display("[TB] FAIL midpass_reset_data mac_x=%h mem_radd=%0d want 0/0", mac_x, mem_radd);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle busy=%b done=%b want 0/0", busy, done);
    end
    clear_logs();
    start_pass();
    run_inputs(1'b0, -1, got);
    repeat (4) next_cycle();
    bad = 0;
    for (int k = 0; k < NW; k++) if (k >= addrs.size() || addrs[k] !== AW'(k)) bad++;
    checks++;
    if (bad != 0 || addrs.size() != NW) begin
      failures++;
      $display("[TB] FAIL reset_readdr bad=%0d reads=%0d want 0 bad and %0d reads", bad, addrs.size(), NW);
    end
    checks++;
    if (done_cyc.size() != 1) begin
      failures++;
      $display("[TB] FAIL reset_done_count got=%0d want=1", done_cyc.size());
    end
  endtask

  task automatic test_full_pass();
    int got;
    clear_logs();
    start_pass();
    run_inputs(1'b0, -1, got);
    repeat (4) next_cycle();
    checks++;
    if (pairs.size() != NW || acc.size() != NW) begin
      failures++;
      $display("[TB] FAIL full_count pairs=%0d accepts=%0d want=%0d", pairs.size(), acc.size(), NW);
    end else begin
      for (int k = 0; k < NW; k++) begin
        checks++;
        if (pairs[k].x !== DW'(100 + k) || pairs[k].w !== rom_val(k) || pairs[k].last !== (k == NW - 1)) begin
          failures++;
          $display("[TB] FAIL full_pair%0d x=%h w=%h last=%b want x=%h w=%h last=%b", k,
                   pairs[k].x, pairs[k].w, pairs[k].last, DW'(100 + k), rom_val(k), k == NW - 1);
        end
      end
      checks++;
      if (pairs[0].c != acc[0] + 1 || pairs[NW-1].c != acc[0] + NW) begin
        failures++;
        $display("[TB] FAIL full_latency first=%0d last=%0d want %0d/%0d",
                 pairs[0].c, pairs[NW-1].c, acc[0] + 1, acc[0] + NW);
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != acc[NW-1] + 2) begin
        failures++;
        $display("[TB] FAIL full_done count=%0d cyc=%0d want 1 at %0d",
                 done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1, acc[NW-1] + 2);
      end
    end
    checks++;
    if (busy_at_done !== 1'b0 || busy_before_done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_busy at_done=%b before=%b want 0/1", busy_at_done, busy_before_done);
    end
    checks++;
    if (ren_bad != 0 || stray_last != 0) begin
      failures++;
      $display("[TB] FAIL full_ren_last ren_bad=%0d stray_last=%0d want 0/0", ren_bad, stray_last);
    end
  endtask

  task automatic test_bubbly();
    int got;
    int bad;
    clear_logs();
    start_pass();
    run_inputs(1'b1, -1, got);
    repeat (4) next_cycle();
    checks++;
    if (pairs.size() != NW || acc.size() != NW) begin
      failures++;
      $display("[TB] FAIL bubbly_count pairs=%0d accepts=%0d want=%0d", pairs.size(), acc.size(), NW);
    end else begin
      bad = 0;
      for (int k = 0; k < NW; k++) begin
        if (pairs[k].x !== DW'(100 + k) || pairs[k].w !== rom_val(k) || pairs[k].last !== (k == NW - 1)) bad++;
        if (pairs[k].c != acc[k] + 1 || acc[k] != acc[0] + 2 * k || addrs[k] !== AW'(k)) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("[TB] FAIL bubbly_pairs bad=%0d want=0", bad);
      end
    end
    checks++;
    if (ren_bad != 0 || done_cyc.size() != 1) begin
      failures++;
      $display("[TB] FAIL bubbly_ren_done ren_bad=%0d dones=%0d want 0/1", ren_bad, done_cyc.size());
    end
  endtask

  task automatic test_start_ignored();
    int got;
    int bad;
    clear_logs();
    start_pass();
    run_inputs(1'b0, 5, got);
    next_cycle();
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL start_done_cycle done=%b want=1", done);
    end
    next_cycle();
    next_cycle();
    start = 1'b0;
    run_inputs(1'b0, -1, got);
    repeat (4) next_cycle();
    bad = 0;
    for (int k = 0; k < 2 * NW; k++) if (k >= addrs.size() || addrs[k] !== AW'(k % NW)) bad++;
    checks++;
    if (bad != 0 || addrs.size() != 2 * NW) begin
      failures++;
      $display("[TB] FAIL start_addrs bad=%0d reads=%0d want 0 bad and %0d reads", bad, addrs.size(), 2 * NW);
    end
    checks++;
    if (done_cyc.size() != 2) begin
      failures++;
      $display("[TB] FAIL start_done_count got=%0d want=2", done_cyc.size());
    end
    checks++;
    if (pairs.size() != 2 * NW || pairs[NW-1].last !== 1'b1 || pairs[NW].c - pairs[NW-1].c != 4) begin
      failures++;
      $display("[TB] FAIL b2b_gap pairs=%0d gap=%0d want %0d pairs gap 4",
               pairs.size(), pairs[NW].c - pairs[NW-1].c, 2 * NW);
    end
  endtask

  task automatic test_idle_input();
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, mem_ren, mac_valid, busy} !== 4'b0) begin
        failures++;
        $display("[TB] FAIL idle_input%0d rdy/ren/val/busy=%b want=0000", k,
                 {in_ready, mem_ren, mac_valid, busy});
      end
      next_cycle();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_timeout();
    clear_logs();
    start_pass();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(700 + k);
      next_cycle();
    end
    in_valid = 1'b0;
    repeat (20) next_cycle();
    @(negedge clk);
`ifdef WSEQ_TIMEOUT_EN
    checks++;
    if (err_cyc.size() != 1 || acc.size() != 3 || err_cyc[0] != acc[2] + TO) begin
      failures++;
      $display("[TB] FAIL timeout_err count=%0d cyc=%0d want 1 at %0d",
               err_cyc.size(), err_cyc.size() > 0 ? err_cyc[0] : -1, acc[2] + TO);
    end
    checks++;
    if (busy !== 1'b0 || done_cyc.size() != 0 || pairs.size() != 3 || stray_last != 0 ||
        pairs[2].last !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_abort busy=%b dones=%0d pairs=%0d want 0/0/3 no last",
               busy, done_cyc.size(), pairs.size());
    end
`else
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || err_cyc.size() != 0) begin
      failures++;
      $display("[TB] FAIL no_timeout busy=%b in_ready=%b errs=%0d want 1/1/0", busy, in_ready, err_cyc.size());
    end
    checks++;
    if (done_cyc.size() != 0 || pairs.size() != 3) begin
      failures++;
      $display("[TB] FAIL no_timeout_pairs dones=%0d pairs=%0d want 0/3", done_cyc.size(), pairs.size());
    end
`endif
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    for (int k = 0; k < NW; k++) rom[k] = rom_val(k);
    test_reset();
    test_full_pass();
    test_bubbly();
    test_start_ignored();
    test_idle_input();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
